// File: rtl/aud_pcm_mixer.sv
// aud_pcm_mixer: per-channel PCM sample FIFOs, a tick-paced saturating mixer
// and a first-order delta-sigma PWM output.
module aud_pcm_mixer #(
    parameter int NCH   = 4,
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 smpValid,
    input  logic [$clog2(NCH > 1 ? NCH : 2)-1:0] smpChan,
    input  logic [W-1:0]                         smpData,
    output logic                                 smpReady,
    input  logic                                 cfgEnable,
    input  logic [NCH-1:0]                       cfgChEna,
    input  logic [15:0]                          cfgRateDiv,
    input  logic                                 underrunClr,
    output logic                                 sampTick,
    output logic [W-1:0]                         mixOut,
    output logic                                 pwmOut,
    output logic                                 pwmEna,
    output logic [NCH-1:0]                       underrun
);
    localparam int CW = $clog2(NCH > 1 ? NCH : 2);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = W + $clog2(NCH);
    localparam logic signed [SW-1:0] mixMax = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] mixMin = ~mixMax;

    logic [15:0] div;
    logic tickD, carry;
    logic [NCH-1:0] full;
    logic signed [W-1:0] hold [NCH];
    logic signed [SW-1:0] sum;
    logic [W-1:0] mixNext, acc, accNext;

    assign sampTick = cfgEnable && div == 16'd0 && !reset;

    always_comb begin
        smpReady = 1'b0;
        for (int k = 0; k < NCH; k++) if (smpChan == CW'(k)) smpReady = !full[k];
    end

    for (genvar i = 0; i < NCH; i++) begin : gCh
        logic [W-1:0] mem [DEPTH];
        logic [AW-1:0] wrPtr, rdPtr;
        logic [AW:0] level;
        logic push, pop, urFlag;
        logic signed [W-1:0] holdReg;
        assign full[i] = level == (AW+1)'(DEPTH);
        assign push = smpValid && smpChan == CW'(i) && !full[i];
        assign pop = sampTick && cfgChEna[i] && level != '0;
        assign hold[i] = holdReg;
        assign underrun[i] = urFlag;
        always_ff @(posedge clock) if (push) mem[wrPtr] <= smpData;
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                wrPtr <= '0;
                rdPtr <= '0;
                level <= '0;
                holdReg <= '0;
                urFlag <= 1'b0;
            end else begin
                wrPtr <= wrPtr + AW'(push);
                rdPtr <= rdPtr + AW'(pop);
                level <= level + (AW+1)'(push) - (AW+1)'(pop);
                if (sampTick) holdReg <= pop ? mem[rdPtr] : '0;
                // a same-cycle push into an empty FIFO is not visible to the tick, so it still underruns
                if (sampTick && cfgChEna[i] && !pop) urFlag <= 1'b1;
                else if (underrunClr) urFlag <= 1'b0;
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < NCH; k++) sum = sum + SW'(hold[k]);
        mixNext = sum > mixMax ? mixMax[W-1:0] : sum < mixMin ? mixMin[W-1:0] : sum[W-1:0];
    end

    // offset-binary accumulate: the carry density tracks (mixOut + 2^(W-1)) / 2^W
    assign {carry, accNext} = {1'b0, acc} + {1'b0, ~mixOut[W-1], mixOut[W-2:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div <= '0;
            tickD <= 1'b0;
            mixOut <= '0;
            acc <= '0;
            pwmOut <= 1'b0;
            pwmEna <= 1'b0;
        end else begin
            div <= !cfgEnable ? 16'd0 : div == 16'd0 ? cfgRateDiv : div - 16'd1;
            tickD <= sampTick;
            if (tickD) mixOut <= mixNext;
            if (cfgEnable) acc <= accNext;
            pwmOut <= cfgEnable && carry;
            pwmEna <= cfgEnable;
        end
    end
endmodule

// File: doc/aud_pcm_mixer.md
AUD_PCM_MIXER -- requirements
Module: aud_pcm_mixer

Interface
- REQ-001 Parameter NCH, default 4, SHALL set the number of mixed PCM channels (1..8).
- REQ-002 Parameter DEPTH, default 16, SHALL set the per-channel sample FIFO depth (power of two, 2..256).
- REQ-003 Parameter W, default 16, SHALL set the sample width (signed two's complement) and the PWM accumulator width.
- REQ-004 The block SHALL have one clock and an asynchronous, active-high reset. Both ports SHALL use the codebase's names, clock and reset:
  - clock  in  1  rising-edge system clock
  - reset  in  1  asynchronous, active-high reset
- REQ-005 The remaining ports SHALL be, one per line (name  direction  width  meaning):
  - smpValid  in  1  sample write strobe
  - smpChan  in  clog2(NCH) (min 1)  target channel index
  - smpData  in  W  signed sample
  - smpReady  out  1  high when the FIFO of smpChan is not full
  - cfgEnable  in  1  output/mixer enable
  - cfgChEna  in  NCH  per-channel enable
  - cfgRateDiv  in  16  sample period minus one, in clocks
  - underrunClr  in  1  clear all underrun flags
  - sampTick  out  1  one-cycle pulse per sample period
  - mixOut  out  W  saturated signed mix
  - pwmOut  out  1  delta-sigma PWM bit
  - pwmEna  out  1  registered copy of cfgEnable
  - underrun  out  NCH  sticky per-channel underrun flags

Function
- REQ-010 A write SHALL be accepted when smpValid && smpReady. Accepted data SHALL be appended to FIFO[smpChan]. A write to a full FIFO, or to smpChan >= NCH, SHALL be dropped with no state change.
- REQ-011 smpReady SHALL be combinational from the current full flag of FIFO[smpChan]. There SHALL be no bypass: a full FIFO that pops in the same cycle still reports smpReady=0.
- REQ-012 FIFOs SHALL accept writes regardless of cfgEnable and cfgChEna.
- REQ-013 The divider SHALL be a 16-bit down-counter:
  - When it is 0 and cfgEnable=1, it reloads cfgRateDiv and sampTick=1 for that cycle.
  - Otherwise it decrements.
  - cfgRateDiv=0 gives sampTick every cycle.
  - A change to cfgRateDiv takes effect at the next reload only.
- REQ-014 While cfgEnable=0, the divider SHALL be held at 0, sampTick SHALL be 0, and no FIFO SHALL pop.
- REQ-015 On sampTick, each channel i SHALL be processed as follows:
  - cfgChEna[i]=1 and FIFO non-empty: pop one sample into a per-channel holding register.
  - cfgChEna[i]=1 and FIFO empty: load 0 into the holding register and set underrun[i].
  - cfgChEna[i]=0: load 0, no pop, no flag change.
- REQ-016 A push and a pop on the same FIFO in the same cycle SHALL both occur, leaving the level unchanged. A push into an empty FIFO coincident with sampTick SHALL still count as an underrun, and the pushed sample SHALL be retained.
- REQ-017 Mix stage, the cycle after sampTick: the holding registers SHALL be sign-extended to W+clog2(NCH) bits and summed. The sum SHALL saturate to [-2^(W-1), 2^(W-1)-1] and be registered into mixOut.
- REQ-018 mixOut SHALL therefore update exactly 2 clocks after the sampTick cycle and SHALL hold between updates.
- REQ-019 PWM: every clock while cfgEnable=1:
  - {carry, acc} = acc + offset-binary(mixOut), where offset-binary means the MSB is inverted.
  - pwmOut SHALL be the registered carry, so the density of pwmOut equals (mixOut + 2^(W-1)) / 2^W.
- REQ-020 While cfgEnable=0, acc SHALL hold its value and pwmOut SHALL be 0. pwmEna SHALL be cfgEnable delayed by one clock.
- REQ-021 underrun[i] SHALL remain set until underrunClr=1. If a clear and a new underrun occur in the same cycle, the set SHALL win.

Reset
- REQ-030 When reset is asserted, the following SHALL be forced asynchronously:
  - all FIFO pointers and levels to 0 (empty)
  - divider, acc, holding registers and mixOut to 0
  - sampTick, pwmOut, pwmEna and underrun to 0
- REQ-031 Reset asserted mid-operation SHALL discard all queued samples. Operation SHALL resume from the empty state on the first clock edge after deassertion.

Verification
- REQ-040 Tick spacing: cfgEnable=1, cfgRateDiv=3, NCH=4, all FIFOs empty -> sampTick every 4 clocks; underrun=4'hF after the first tick; mixOut stays 0.
- REQ-041 Push and mix: push ch0=0x1000 and ch1=0x0200, cfgChEna=4'b0011 -> mixOut=0x1200 two clocks after the next sampTick; FIFOs 0 and 1 end empty; underrun stays 0.
- REQ-042 Saturation: four channels each push 0x7000 -> mixOut=0x7FFF; four channels each push 0x9000 -> mixOut=0x8000.
- REQ-043 Full FIFO (DEPTH=16): push 16 samples to ch2 with cfgEnable=0 -> smpReady=0 for ch2; a 17th push is dropped; enable the block and pop 16 samples; the 17th value never appears in mixOut.
- REQ-044 PWM density: hold mixOut=0x4000 (W=16) for 1024 clocks -> pwmOut high count = 768 (±1); mixOut=0x8000 -> pwmOut constantly 0.
- REQ-045 Reset mid-stream: assert reset with 5 samples queued -> all outputs 0 immediately; after release, the next tick reports an underrun and mixOut=0.
